// File: rtl/reg_share_pkg.sv
// Shared types and width helpers for the shared-register arbiter.
// Imported by the picker and the arbiter top.
package reg_share_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int hold);
        return (hold > 0) ? $clog2(hold + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N.
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    int idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                winner   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// One shared capture register fed by N requesters under round-robin
// arbitration, followed by a fixed busy window per write.
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int   WIDTH       = 8,
    parameter int   N           = 4,
    parameter int   HOLD_CYCLES = 2,
    localparam int  IDX_W       = idx_width(N)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N-1:0]       i_req,
    input  logic [N*WIDTH-1:0] i_data,
    output logic [N-1:0]       o_gnt,
    output logic [WIDTH-1:0]   o_q,
    output logic               o_q_valid,
    output logic [IDX_W-1:0]   o_owner,
    output logic               o_busy
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [N-1:0]     pick_gnt;
    logic [IDX_W-1:0] win;
    logic             any;
    logic             grant;

    rr_priority_picker #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (i_req),
        .ptr    (ptr),
        .gnt    (pick_gnt),
        .winner (win),
        .any    (any)
    );

    assign grant    = (state == IDLE) && any && !i_rst;
    assign o_gnt    = grant ? pick_gnt : '0;
    assign o_busy   = (state == HOLD);
    assign ptr_next = (win == IDX_W'(N - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            o_q       <= '0;
            o_q_valid <= 1'b0;
            o_owner   <= '0;
        end else begin
            o_q_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        o_q       <= i_data[int'(win)*WIDTH +: WIDTH];
                        o_owner   <= win;
                        o_q_valid <= 1'b1;
                        ptr       <= ptr_next;
                        // zero hold keeps the arbiter in IDLE for back-to-back grants
                        if (HOLD_CYCLES > 0) begin
                            state <= HOLD;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench: captures are predicted at grant time and checked
// when o_q_valid pulses; grants and busy are checked directly.
module tb_reg_share_arbiter;

    typedef struct {
        logic [1:0] owner;
        logic [7:0] q;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        qv;
    logic [1:0]  owner;
    logic        busy;

    logic [3:0]  req_z;
    logic [31:0] data_z;
    logic [3:0]  gnt_z;
    logic [7:0]  q_z;
    logic        qv_z;
    logic [1:0]  owner_z;
    logic        busy_z;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];
    exp_t sbz[$];

    reg_share_arbiter #(.WIDTH(8), .N(4), .HOLD_CYCLES(2)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_data    (data),
        .o_gnt     (gnt),
        .o_q       (q),
        .o_q_valid (qv),
        .o_owner   (owner),
        .o_busy    (busy)
    );

    reg_share_arbiter #(.WIDTH(8), .N(4), .HOLD_CYCLES(0)) dut_z (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req_z),
        .i_data    (data_z),
        .o_gnt     (gnt_z),
        .o_q       (q_z),
        .o_q_valid (qv_z),
        .o_owner   (owner_z),
        .o_busy    (busy_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] d);
        exp_t e;
        e.owner = 2'(k);
        e.q     = d;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) chk("idle_timeout", 32'(n), 0);
    endtask

    always @(negedge clk) begin
        if (qv === 1'b1) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=%h/%0d required=none",
                         q, owner);
            end else begin
                e = sb.pop_front();
                if (q !== e.q || owner !== e.owner) begin
                    failures++;
                    $display("FAIL sb_capture actual=%h/%0d required=%h/%0d",
                             q, owner, e.q, e.owner);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (qv_z === 1'b1) begin
            exp_t e;
            checks++;
            if (sbz.size() == 0) begin
                failures++;
                $display("FAIL sbz_unexpected actual=%h/%0d required=none",
                         q_z, owner_z);
            end else begin
                e = sbz.pop_front();
                if (q_z !== e.q || owner_z !== e.owner) begin
                    failures++;
                    $display("FAIL sbz_capture actual=%h/%0d required=%h/%0d",
                             q_z, owner_z, e.q, e.owner);
                end
            end
        end
    end

    initial begin
        int n;
        int k;
        exp_t ez;

        rst    = 1'b1;
        req    = 4'b1111;
        data   = {8'h13, 8'h12, 8'h11, 8'h10};
        req_z  = 4'b0000;
        data_z = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        // reset with all requesting
        repeat (2) tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_qv", 32'(qv), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        #1;

        // round robin with continuous requests
        for (int g = 0; g < 5; g++) begin
            k = g % 4;
            n = 0;
            while (gnt == 4'b0000 && n < 10) begin
                tick();
                n++;
            end
            if (n >= 10) chk("rr_timeout", 32'(n), 0);
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << k));
            if (g > 0) chk("rr_spacing", 32'(n + 1), 3);
            push(k, 8'h10 + 8'(k));
            tick();
        end

        // single requester, hold window, data ignored outside grant edge
        req = 4'b0000;
        wait_idle();
        data[23:16] = 8'hA5;
        req = 4'b0100;
        #1;
        chk("single_gnt", 32'(gnt), 32'(4'b0100));
        push(2, 8'hA5);
        tick();
        chk("single_busy1", 32'(busy), 1);
        chk("single_gnt_hold", 32'(gnt), 0);
        data[23:16] = 8'h5A;
        tick();
        chk("single_busy2", 32'(busy), 1);
        chk("single_q_hold", 32'(q), 32'(8'hA5));
        chk("single_qv_low", 32'(qv), 0);
        tick();
        chk("single_busy_end", 32'(busy), 0);
        chk("single_regrant", 32'(gnt), 32'(4'b0100));
        req = 4'b0000;
        #1;
        chk("single_drop", 32'(gnt), 0);

        // ptr=3: skip to 1, then search 2,3,0
        tick();
        req = 4'b0010;
        #1;
        chk("wrap_gnt1", 32'(gnt), 32'(4'b0010));
        push(1, 8'h11);
        repeat (3) tick();
        req = 4'b0011;
        #1;
        chk("wrap_gnt0", 32'(gnt), 32'(4'b0001));
        push(0, 8'h10);
        tick();
        req = 4'b0000;
        repeat (2) tick();

        // reset during hold
        data[15:8] = 8'h3C;
        req = 4'b0010;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'(4'b0010));
        push(1, 8'h3C);
        tick();
        rst = 1'b1;
        req = 4'b1010;
        tick();
        chk("midrst_q", 32'(q), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_owner", 32'(owner), 0);
        chk("midrst_qv", 32'(qv), 0);
        chk("midrst_gnt_rst", 32'(gnt), 0);
        rst = 1'b0;
        #1;
        chk("midrst_ptr0", 32'(gnt), 32'(4'b0010));
        push(1, 8'h3C);
        tick();
        req = 4'b0000;
        repeat (3) tick();

        // zero-hold build: back-to-back alternating grants
        req_z = 4'b1001;
        #1;
        for (int i = 0; i < 4; i++) begin
            k = (i % 2 == 0) ? 0 : 3;
            chk("z_gnt", 32'(gnt_z), 32'(4'b0001 << k));
            chk("z_busy", 32'(busy_z), 0);
            if (i > 0) chk("z_qv", 32'(qv_z), 1);
            ez.owner = 2'(k);
            ez.q     = (k == 0) ? 8'hA0 : 8'hD3;
            sbz.push_back(ez);
            tick();
        end
        req_z = 4'b0000;
        repeat (2) tick();

        chk("sb_drained", 32'(sb.size()), 0);
        chk("sbz_drained", 32'(sbz.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
